rv32m_seq_mdu: RTL and testbench

- Multi-cycle RV32M multiply/divide responder that replaces the single-cycle combinational M-extension path beside the ALU.
- The pipeline issues an operation over a valid/ready request channel. The unit iterates one bit per cycle and returns the 32-bit result over a valid/ready response channel.
- Results are bit-exact with the ALU's RV32M results, including the divide-by-zero and overflow corner cases.

---
 rtl/rv32m_seq_mdu.sv | 153 +++++++++++++++
 tb/tb_rv32m_seq_mdu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_seq_mdu.sv
// rv32m_seq_mdu: bit-serial RV32M multiply/divide unit with valid/ready request and response channels.
// Build option MDU_FAST_MUL_EN: multiplies complete in one cycle at accept; divides stay iterative.
module rv32m_seq_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy,
    output logic [1:0]      dbg_state_o
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high; once
    // valid is raised it stays high with a stable payload until that transfer or a kill.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
    state_e state_q, state_d;

    logic [2:0]        op_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   opb_q, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    logic              accept, a_signed, b_signed, a_neg, b_neg, neg_now;
    logic              special, last_step, load_result, div_ge;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, final_res, div_rem, quo_s, rem_s;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_s;
`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_p;
`endif

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (req_funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg  = a_signed & req_a[XLEN-1];
    assign b_neg  = b_signed & req_b[XLEN-1];
    assign mag_a  = a_neg ? -req_a : req_a;
    assign mag_b  = b_neg ? -req_b : req_b;
    // Remainders follow the dividend's sign; products and quotients follow the sign parity.
    assign neg_now = (req_funct3[2] & req_funct3[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MDU_FAST_MUL_EN
    assign fast_mag = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fast_p   = neg_now ? -fast_mag : fast_mag;
`endif

    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (req_funct3[2]) begin
            if (req_b == '0) begin
                special     = 1'b1;
                special_res = req_funct3[1] ? req_a : '1;
            end else if (!req_funct3[0] && req_a == {1'b1, {(XLEN-1){1'b0}}} && req_b == '1) begin
                special     = 1'b1;
                special_res = req_funct3[1] ? '0 : req_a;
            end
        end else begin
`ifdef MDU_FAST_MUL_EN
            special     = 1'b1;
            special_res = (req_funct3[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`else
            special     = (req_a == '0) || (req_b == '0);
`endif
        end
    end

    // acc_q holds {hi, lo}: product accumulator/multiplier for mul, remainder/quotient for div.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_ge  = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opb_q};
    assign div_rem = div_ge ? (acc_q[2*XLEN-2:XLEN-1] - opb_q) : acc_q[2*XLEN-2:XLEN-1];
    assign acc_d   = op_q[2] ? {div_rem, acc_q[XLEN-2:0], div_ge} : {mul_sum, acc_q[XLEN-1:1]};

    assign prod_s = neg_q ? -acc_d : acc_d;
    assign quo_s  = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    assign rem_s  = neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];

    always_comb begin
        if (op_q[2]) final_res = op_q[1] ? rem_s : quo_s;
        else final_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    assign accept      = (state_q == IDLE) & req_valid & ~kill;
    assign last_step   = (state_q == CALC) & (cnt_q == CNT_W'(XLEN-1));
    assign load_result = (accept & special) | (last_step & ~kill);
    assign result_d    = accept ? special_res : final_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (kill) state_d = IDLE;
                     else if (last_step) state_d = DONE;
            DONE:    if (kill || resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = (state_q == DONE);
        busy        = (state_q != IDLE);
        resp_result = result_q;
        dbg_state_o = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_funct3;
                neg_q <= neg_now;
                opb_q <= mag_b;
                acc_q <= {{XLEN{1'b0}}, mag_a};
                cnt_q <= '0;
            end else if (state_q == CALC) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_result) result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_rv32m_seq_mdu.sv
// tb_rv32m_seq_mdu: directed vectors for rv32m_seq_mdu covering results, latency, backpressure,
// kill and asynchronous reset. Expected values are hand-computed.
module tb_rv32m_seq_mdu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    int          n_total = 0;
    int          n_bad = 0;

    localparam int NORM_LAT = 33;
    localparam int SPEC_LAT = 1;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    rv32m_seq_mdu dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_a       (req_a),
        .req_b       (req_b),
        .kill        (kill),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic wait_resp(input string tag, input int exp_lat);
        int lat;
        logic [31:0] exp;
        lat = 1;
        while (!resp_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " lat"}, 32'(lat), 32'(exp_lat));
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check({tag, " res"}, resp_result, exp);
            last_res = exp;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        exp_q.push_back(exp);
        issue(f3, a, b);
        check({tag, " rdy"}, {31'd0, req_ready}, 32'd0);
        wait_resp(tag, exp_lat);
        @(posedge clk);
        #1;
        check({tag, " retire"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int rises;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_a      = '0;
        req_b      = '0;
        kill       = 1'b0;
        resp_ready = 1'b1;
        last_res   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst result", resp_result, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("mul 7*6",       3'd0, 32'd7,          32'd6,          32'd42,         MUL_LAT);
        do_op("mul -3*5",      3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  MUL_LAT);
        do_op("mul 0*123",     3'd0, 32'd0,          32'd123,        32'd0,          SPEC_LAT);
        do_op("mulh",          3'd1, 32'hFFFF_FC18,  32'd1000,       32'hFFFF_FFFF,  MUL_LAT);
        do_op("mulh min*min",  3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  MUL_LAT);
        do_op("mulhsu",        3'd2, 32'hFFFF_FFFF,  32'h8000_0000,  32'hFFFF_FFFF,  MUL_LAT);
        do_op("mulhu",         3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT);
        do_op("div 42/6",      3'd4, 32'd42,         32'd6,          32'd7,          NORM_LAT);
        do_op("div -43/6",     3'd4, 32'hFFFF_FFD5,  32'd6,          32'hFFFF_FFF9,  NORM_LAT);
        do_op("div by 0",      3'd4, 32'd42,         32'd0,          32'hFFFF_FFFF,  SPEC_LAT);
        do_op("div ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPEC_LAT);
        do_op("rem by 0",      3'd6, 32'd43,         32'd0,          32'd43,         SPEC_LAT);
        do_op("rem ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPEC_LAT);
        do_op("rem -43%6",     3'd6, 32'hFFFF_FFD5,  32'd6,          32'hFFFF_FFFF,  NORM_LAT);
        do_op("divu",          3'd5, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  NORM_LAT);
        do_op("divu by 0",     3'd5, 32'd42,         32'd0,          32'hFFFF_FFFF,  SPEC_LAT);
        do_op("remu",          3'd7, 32'hFFFF_FFFF,  32'd10,         32'd5,          NORM_LAT);
        do_op("remu by 0",     3'd7, 32'd7,          32'd0,          32'd7,          SPEC_LAT);

        // Backpressure: hold the response for 5 cycles, then retire and issue immediately.
        resp_ready = 1'b0;
        exp_q.push_back(32'd14);
        issue(3'd4, 32'd100, 32'd7);
        wait_resp("bp", NORM_LAT);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp hold valid", {31'd0, resp_valid}, 32'd1);
            check("bp hold res", resp_result, 32'd14);
            check("bp hold rdy", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp retire valid", {31'd0, resp_valid}, 32'd0);
        check("bp retire rdy", {31'd0, req_ready}, 32'd1);
        check("bp idle res", resp_result, 32'd14);
        exp_q.push_back(32'd7);
        issue(3'd4, 32'd42, 32'd6);
        check("bp next busy", {31'd0, busy}, 32'd1);
        wait_resp("bp next", NORM_LAT);
        @(posedge clk);
        #1;

        // Kill during CALC: no response may follow and the held result is untouched.
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        check("kill pre busy", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill busy", {31'd0, busy}, 32'd0);
        check("kill valid", {31'd0, resp_valid}, 32'd0);
        check("kill rdy", {31'd0, req_ready}, 32'd1);
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) rises++;
        end
        check("kill no resp", 32'(rises), 32'd0);
        check("kill held res", resp_result, last_res);

        // kill and req_valid together in IDLE: kill wins.
        @(negedge clk);
        req_funct3 = 3'd4;
        req_a      = 32'd42;
        req_b      = 32'd6;
        req_valid  = 1'b1;
        kill       = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        check("idle kill busy", {31'd0, busy}, 32'd0);
        check("idle kill state", {30'd0, dbg_state}, 32'd0);

        // Kill while DONE is being held by backpressure.
        resp_ready = 1'b0;
        issue(3'd4, 32'd42, 32'd0);
        check("done kill pre", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        resp_ready = 1'b1;
        check("done kill valid", {31'd0, resp_valid}, 32'd0);
        check("done kill busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-CALC.
        issue(3'd5, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst req_ready", {31'd0, req_ready}, 32'd1);
        check("arst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("arst result", resp_result, 32'd0);
        check("arst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("divu post rst", 3'd5, 32'd1000, 32'd3, 32'd333, NORM_LAT);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
